// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: accepts a word on load/ready and shifts it
// out one bit per clock, MSB- or LSB-first, with sen framing and a last-bit done pulse.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             OP,
  output logic             ready,
  output logic             sdata,
  output logic             sen,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend only on registered state, so there is no load-to-ready path.
  always_comb begin
    last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    ready    = (state_q == IDLE) || last_bit;
    done     = last_bit;
    sen      = (state_q == SHIFT);
    sdata    = 1'b0;
    if (state_q == SHIFT) begin
      sdata = op_q ? sr_q[WIDTH-1] : sr_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = din;
          op_d    = OP;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = op_q ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // Reloading on the last bit keeps the serial stream gap-free.
          if (load) begin
            sr_d  = din;
            op_d  = OP;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed cases from the test plan plus random
// traffic scored against a bit-queue model of the serial stream.
module tb_piso_tx;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         load = 1'b0;
  logic         OP = 1'b0;
  logic         ready, sdata, sen, done;

  piso_tx #(.WIDTH(W)) dut (
    .CLK(CLK), .reset_n(reset_n), .din(din), .load(load), .OP(OP),
    .ready(ready), .sdata(sdata), .sen(sen), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queue of bits still to appear on the line, and how many remain in the current frame.
  bit    exp_q[$];
  int    m_rem = 0;
  logic [31:0] cap;
  int    cap_n;
  int    done_n;
  int    done_cyc[$];
  int    cyc = 0;
  logic [W-1:0] rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clr_cap();
    cap = '0;
    cap_n = 0;
    done_n = 0;
    done_cyc.delete();
  endtask

  // One clock: check outputs on the falling edge, then advance the model on the rising edge.
  task automatic step();
    bit rdy;
    bit s_sen, s_dat;
    @(negedge CLK);
    chk("sen", {31'd0, sen}, {31'd0, (m_rem > 0)});
    chk("ready", {31'd0, ready}, {31'd0, (m_rem <= 1)});
    chk("done", {31'd0, done}, {31'd0, (m_rem == 1)});
    if (m_rem > 0) chk("sdata", {31'd0, sdata}, {31'd0, exp_q[0]});
    else           chk("sdata_idle", {31'd0, sdata}, 32'd0);
    s_sen = sen;
    s_dat = sdata;
    if (sen) begin
      cap = {cap[30:0], sdata};
      cap_n++;
    end
    if (done) begin
      done_n++;
      done_cyc.push_back(cyc);
    end
    @(posedge CLK);
    if (reset_n) begin
      rdy = (m_rem <= 1);
      if (m_rem > 0) begin
        void'(exp_q.pop_front());
        m_rem--;
      end
      if (load && rdy) begin
        for (int i = 0; i < W; i++) exp_q.push_back(OP ? din[W-1-i] : din[i]);
        m_rem = W;
      end
      if (s_sen) rx = {rx[W-2:0], s_dat};
    end
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input logic o);
    din = d;
    OP = o;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must respond before any clock edge.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_sen", {31'd0, sen}, 32'd0);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    m_rem = 0;
    load = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rx = '0;
    clr_cap();
    step();
    step();
    reset_n = 1'b1;
    step();

    // MSB-first 0xC1
    clr_cap();
    send(8'hC1, 1'b1);
    for (int i = 0; i < W + 2; i++) step();
    chk("msb_seq", cap, 32'h0000_00C1);
    chk("msb_dones", done_n, 1);
    chk("msb_done_pos", done_cyc[0], cyc - 3);

    // LSB-first 0xC1 with OP toggling mid-frame
    clr_cap();
    send(8'hC1, 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      OP = ~OP;
      din = ~din;
      step();
    end
    chk("lsb_seq", cap, 32'h0000_0083);
    chk("lsb_bits", cap_n, 8);

    // Back-to-back: second word applied on the first word's last-bit cycle
    clr_cap();
    send(8'hC1, 1'b1);
    load = 1'b1;
    for (int i = 0; i < W - 1; i++) step();
    din = 8'h0F;
    OP = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < W + 2; i++) step();
    chk("b2b_seq", cap, 32'h0000_C1F0);
    chk("b2b_bits", cap_n, 16);
    chk("b2b_dones", done_n, 2);
    chk("b2b_spacing", done_cyc[1] - done_cyc[0], W);

    // Load while busy is ignored
    clr_cap();
    send(8'h00, 1'b1);
    step();
    step();
    din = 8'hFF;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < W + 4; i++) step();
    chk("busy_seq", cap, 32'd0);
    chk("busy_bits", cap_n, 8);
    chk("busy_ready", {31'd0, ready}, 32'd1);

    // Reset at bit 4, then loopback 0x5A into an MSB-first receiver
    clr_cap();
    send(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) step();
    async_reset();
    chk("rst_nodone", done_n, 0);
    rx = '0;
    clr_cap();
    send(8'h5A, 1'b1);
    for (int i = 0; i < W; i++) step();
    chk("loop_rx", {24'd0, rx}, 32'h5A);
    step();

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      load = ($urandom_range(0, 2) != 0);
      din = W'($urandom);
      OP = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 149) == 0) async_reset();
      else step();
    end
    load = 1'b0;
    for (int i = 0; i < W + 2; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
